// File: rtl/sfp_id_reader.sv
// SFP serial-ID reader: two-wire master that fetches NUM_BYTES from the module EEPROM.
// Define SFP_ID_CHECKSUM_EN to build the CC_BASE checksum check over offsets 0..63.
module sfp_id_reader #(
   parameter int         CLK_DIV   = 100,
   parameter int         NUM_BYTES = 64,
   parameter logic [6:0] DEV_ADDR  = 7'h50
) (
   input  logic       i_clk,
   input  logic       i_res_n,
   input  logic       i_start,
   input  logic       i_mod_def0,
   input  logic       i_scl,
   input  logic       i_sda,
   output logic       o_scl_oe,
   output logic       o_sda_oe,
   output logic       o_busy,
   output logic [7:0] o_data,
   output logic [7:0] o_addr,
   output logic       o_valid,
   output logic       o_done,
   output logic       o_err,
   output logic       o_cks_ok
);

   localparam int             CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0]  CNT_MAX  = CW'(CLK_DIV - 1);
   localparam logic [7:0]     LAST_IDX = 8'(NUM_BYTES - 1);

   typedef enum logic [3:0] {
      IDLE, START, ADDR_W, WORD_ADDR, RSTART, ADDR_R, READ, MACK, STOP, DONE
   } state_t;

   state_t          state_reg, state_next;
   logic [CW-1:0]   cnt_reg, cnt_next;
   logic [1:0]      q_reg, q_next;
   logic [3:0]      bit_cnt_reg, bit_cnt_next;
   logic [7:0]      shift_reg, shift_next;
   logic [7:0]      rx_idx_reg, rx_idx_next;
   logic [7:0]      data_reg, data_next;
   logic [7:0]      addr_reg, addr_next;
   logic            valid_reg, valid_next;
   logic            err_reg, err_next;
   logic            nack_reg, nack_next;
   logic            last_reg, last_next;
   logic            abort_reg, abort_next;
   logic            sda_oe_reg;
   logic [1:0]      scl_sync_reg, sda_sync_reg;

   logic            scl_in, sda_in;
   logic            scl_drive, sda_drive;
   logic            stretch, tick, sample, bit_end, start_req;

   assign scl_in    = scl_sync_reg[1];
   assign sda_in    = sda_sync_reg[1];
   assign o_busy    = (state_reg != IDLE) && (state_reg != DONE);
   assign o_done    = (state_reg == DONE);
   assign o_scl_oe  = scl_drive;
   assign o_sda_oe  = sda_oe_reg;
   assign o_data    = data_reg;
   assign o_addr    = addr_reg;
   assign o_valid   = valid_reg;
   assign o_err     = err_reg;
   assign start_req = (state_reg == IDLE) && i_start;

   // A released SCL still seen low means the slave is stretching the clock.
   assign stretch = !scl_drive && !scl_in;
   assign tick    = o_busy && !stretch && (cnt_reg == CNT_MAX);
   assign sample  = tick && (q_reg == 2'd2);
   assign bit_end = tick && (q_reg == 2'd3);

   always_comb begin
      scl_drive = 1'b0;
      sda_drive = 1'b0;
      case (state_reg)
         START:  sda_drive = q_reg[1];
         RSTART: begin
            scl_drive = !q_reg[1];
            sda_drive = (q_reg == 2'd3);
         end
         ADDR_W, WORD_ADDR, ADDR_R: begin
            scl_drive = !q_reg[1];
            sda_drive = (bit_cnt_reg != 4'd8) && !shift_reg[7];
         end
         READ:   scl_drive = !q_reg[1];
         MACK: begin
            scl_drive = !q_reg[1];
            sda_drive = !last_reg;
         end
         STOP: begin
            scl_drive = !q_reg[1];
            sda_drive = (q_reg != 2'd3);
         end
         default: ;
      endcase
   end

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      q_next       = q_reg;
      bit_cnt_next = bit_cnt_reg;
      shift_next   = shift_reg;
      rx_idx_next  = rx_idx_reg;
      data_next    = data_reg;
      addr_next    = addr_reg;
      valid_next   = 1'b0;
      err_next     = err_reg;
      nack_next    = nack_reg;
      last_next    = last_reg;
      abort_next   = abort_reg | (o_busy & i_mod_def0);

      if (!o_busy) begin
         cnt_next = '0;
         q_next   = 2'd0;
      end else if (!stretch) begin
         if (cnt_reg == CNT_MAX) begin
            cnt_next = '0;
            q_next   = q_reg + 2'd1;
         end else begin
            cnt_next = cnt_reg + CW'(1);
         end
      end

      case (state_reg)
         IDLE: begin
            if (i_start) begin
               if (!i_mod_def0) begin
                  state_next  = START;
                  err_next    = 1'b0;
                  abort_next  = 1'b0;
                  rx_idx_next = 8'd0;
                  last_next   = 1'b0;
               end else begin
                  state_next = DONE;
                  err_next   = 1'b1;
               end
            end
         end
         START: begin
            if (bit_end) begin
               state_next   = ADDR_W;
               shift_next   = {DEV_ADDR, 1'b0};
               bit_cnt_next = 4'd0;
            end
         end
         ADDR_W, WORD_ADDR, ADDR_R: begin
            if (sample && (bit_cnt_reg == 4'd8))
               nack_next = sda_in;
            if (bit_end) begin
               if (bit_cnt_reg != 4'd8) begin
                  bit_cnt_next = bit_cnt_reg + 4'd1;
                  shift_next   = {shift_reg[6:0], 1'b0};
               end else begin
                  bit_cnt_next = 4'd0;
                  if (nack_reg) begin
                     state_next = STOP;
                     err_next   = 1'b1;
                  end else if (state_reg == ADDR_W) begin
                     state_next = WORD_ADDR;
                     shift_next = 8'h00;
                  end else if (state_reg == WORD_ADDR) begin
                     state_next = RSTART;
                  end else begin
                     state_next = READ;
                  end
               end
            end
         end
         RSTART: begin
            if (bit_end) begin
               state_next   = ADDR_R;
               shift_next   = {DEV_ADDR, 1'b1};
               bit_cnt_next = 4'd0;
            end
         end
         READ: begin
            if (sample) begin
               shift_next = {shift_reg[6:0], sda_in};
               if (bit_cnt_reg == 4'd7) begin
                  data_next   = {shift_reg[6:0], sda_in};
                  addr_next   = rx_idx_reg;
                  valid_next  = 1'b1;
                  last_next   = (rx_idx_reg == LAST_IDX);
                  rx_idx_next = rx_idx_reg + 8'd1;
               end
            end
            if (bit_end) begin
               if (bit_cnt_reg == 4'd7) begin
                  state_next   = MACK;
                  bit_cnt_next = 4'd0;
               end else begin
                  bit_cnt_next = bit_cnt_reg + 4'd1;
               end
            end
         end
         MACK: begin
            if (bit_end)
               state_next = last_reg ? STOP : READ;
         end
         STOP: begin
            if (bit_end) begin
               state_next = DONE;
               err_next   = err_reg | abort_next;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase

      // Module removal ends the frame cleanly at the next bit boundary.
      if (bit_end && abort_next && (state_reg != STOP)) begin
         state_next = STOP;
         err_next   = 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_res_n) begin
      if (!i_res_n) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         q_reg        <= 2'd0;
         bit_cnt_reg  <= 4'd0;
         shift_reg    <= 8'h00;
         rx_idx_reg   <= 8'd0;
         data_reg     <= 8'h00;
         addr_reg     <= 8'h00;
         valid_reg    <= 1'b0;
         err_reg      <= 1'b0;
         nack_reg     <= 1'b0;
         last_reg     <= 1'b0;
         abort_reg    <= 1'b0;
         sda_oe_reg   <= 1'b0;
         scl_sync_reg <= 2'b11;
         sda_sync_reg <= 2'b11;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         q_reg        <= q_next;
         bit_cnt_reg  <= bit_cnt_next;
         shift_reg    <= shift_next;
         rx_idx_reg   <= rx_idx_next;
         data_reg     <= data_next;
         addr_reg     <= addr_next;
         valid_reg    <= valid_next;
         err_reg      <= err_next;
         nack_reg     <= nack_next;
         last_reg     <= last_next;
         abort_reg    <= abort_next;
         // SDA lags SCL by one clock so data never moves near the SCL falling edge.
         sda_oe_reg   <= sda_drive;
         scl_sync_reg <= {scl_sync_reg[0], i_scl};
         sda_sync_reg <= {sda_sync_reg[0], i_sda};
      end
   end

`ifdef SFP_ID_CHECKSUM_EN
   logic [7:0] cks_acc_reg;
   logic       cks_match_reg;
   logic       cks_ok_reg;

   always_ff @(posedge i_clk or negedge i_res_n) begin
      if (!i_res_n) begin
         cks_acc_reg   <= 8'h00;
         cks_match_reg <= 1'b0;
         cks_ok_reg    <= 1'b0;
      end else if (start_req) begin
         cks_acc_reg   <= 8'h00;
         cks_match_reg <= 1'b0;
         cks_ok_reg    <= 1'b0;
      end else begin
         if (valid_reg && (addr_reg < 8'd63))
            cks_acc_reg <= cks_acc_reg + data_reg;
         if (valid_reg && (addr_reg == 8'd63))
            cks_match_reg <= (data_reg == cks_acc_reg);
         if ((state_reg == STOP) && (state_next == DONE))
            cks_ok_reg <= cks_match_reg && !err_next && (NUM_BYTES >= 64);
      end
   end

   assign o_cks_ok = cks_ok_reg;
`else
   assign o_cks_ok = 1'b0;
`endif

endmodule

// File: tb/tb_sfp_id_reader.sv
// Bench for sfp_id_reader: open-drain bus with a behavioural SFP EEPROM slave and a byte scoreboard.
// Checksum expectations follow SFP_ID_CHECKSUM_EN when it is defined for the build.
module tb_sfp_id_reader;

   localparam int CLK_DIV   = 4;
   localparam int NUM_BYTES = 64;
   localparam int BUDGET    = 20000;
`ifdef SFP_ID_CHECKSUM_EN
   localparam bit CKS_EN = 1'b1;
`else
   localparam bit CKS_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       res_n = 1'b0;
   logic       start = 1'b0;
   logic       mod_def0 = 1'b0;
   logic       scl_oe, sda_oe, busy, valid, done, err, cks_ok;
   logic [7:0] data, addr;
   logic       slv_scl_low = 1'b0;
   logic       slv_sda_low = 1'b0;

   wire scl = ~(scl_oe | slv_scl_low);
   wire sda = ~(sda_oe | slv_sda_low);

   always #5 clk = ~clk;

   sfp_id_reader #(.CLK_DIV(CLK_DIV), .NUM_BYTES(NUM_BYTES), .DEV_ADDR(7'h50)) dut (
      .i_clk(clk), .i_res_n(res_n), .i_start(start), .i_mod_def0(mod_def0),
      .i_scl(scl), .i_sda(sda), .o_scl_oe(scl_oe), .o_sda_oe(sda_oe), .o_busy(busy),
      .o_data(data), .o_addr(addr), .o_valid(valid), .o_done(done), .o_err(err),
      .o_cks_ok(cks_ok)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, want);
      end
   endtask

   // ---------------- EEPROM slave model ----------------
   logic [7:0] mem [0:63];
   logic [7:0] frames [$];
   int   stop_cnt = 0;
   int   bitn = 0;
   int   tx_ptr = 0;
   logic prev_scl = 1'b1, prev_sda = 1'b1;
   logic s_active = 1'b0, s_tx = 1'b0, s_addr = 1'b0, s_read = 1'b0, s_acked = 1'b0, mack = 1'b0;
   logic [7:0] rx = 8'h00, txb = 8'h00;
   bit   nack_a0 = 1'b0;
   int   stretch_byte = -1;
   int   stretch_left = 0;
   int   hi_cnt = 0, hi_meas = 0;
   bit   meas_on = 1'b0;
   bit   stretched = 1'b0;

   task automatic load_byte();
      txb = mem[tx_ptr % 64];
      slv_sda_low = ~txb[7];
      if (tx_ptr == stretch_byte) begin
         slv_scl_low  = 1'b1;
         stretch_left = 500;
         stretched    = 1'b1;
      end
      tx_ptr++;
   endtask

   always @(negedge clk) begin
      if (!res_n) begin
         s_active = 0; s_tx = 0; bitn = 0; slv_sda_low = 0; slv_scl_low = 0;
         stretch_left = 0; meas_on = 0; prev_scl = 1; prev_sda = 1;
      end else begin
         if (stretch_left > 0) begin
            stretch_left--;
            if (stretch_left == 0) begin
               slv_scl_low = 1'b0;
               meas_on = 1'b1;
               hi_cnt = 0;
            end
         end
         if (meas_on) begin
            if (scl) hi_cnt++;
            else if (hi_cnt > 0) begin
               hi_meas = hi_cnt;
               meas_on = 1'b0;
            end
         end
         if (prev_scl && scl && prev_sda && !sda) begin
            s_active = 1; s_tx = 0; s_addr = 1; bitn = 0; slv_sda_low = 0;
         end else if (prev_scl && scl && !prev_sda && sda) begin
            stop_cnt++;
            s_active = 0; slv_sda_low = 0;
         end else if (s_active && !prev_scl && scl) begin
            if (bitn < 8 && !s_tx) rx = {rx[6:0], sda};
            if (bitn == 8 && s_tx) mack = sda;
            bitn++;
         end else if (s_active && prev_scl && !scl) begin
            if (!s_tx) begin
               if (bitn == 8) begin
                  frames.push_back(rx);
                  if (s_addr) begin
                     s_read  = rx[0];
                     s_acked = (rx[7:1] == 7'h50) && !(nack_a0 && !rx[0]);
                     s_addr  = 0;
                  end else begin
                     tx_ptr  = int'(rx);
                     s_acked = 1;
                  end
                  slv_sda_low = s_acked;
               end else if (bitn == 9) begin
                  slv_sda_low = 0;
                  bitn = 0;
                  if (!s_acked) s_active = 0;
                  else if (s_read) begin
                     s_tx = 1;
                     load_byte();
                  end
               end
            end else begin
               if (bitn >= 1 && bitn <= 7) slv_sda_low = ~txb[7 - bitn];
               else if (bitn == 8) slv_sda_low = 0;
               else if (bitn == 9) begin
                  bitn = 0;
                  if (!mack) load_byte();
                  else begin
                     s_active = 0;
                     slv_sda_low = 0;
                  end
               end
            end
         end
         prev_scl = scl;
         prev_sda = sda;
      end
   end

   // ---------------- scoreboard ----------------
   logic [15:0] exp_q [$];
   logic [15:0] exp_e;
   int   valid_cnt = 0;
   bit   drove = 1'b0;

   always @(negedge clk) begin
      if (scl_oe || sda_oe) drove = 1'b1;
      if (res_n && valid) begin
         valid_cnt++;
         if (exp_q.size() == 0) check("valid_extra", 1, 0);
         else begin
            exp_e = exp_q.pop_front();
            check("byte_addr", addr, exp_e[15:8]);
            check("byte_data", data, exp_e[7:0]);
         end
      end
   end

   function automatic bit cks_expected();
      logic [7:0] s;
      s = 8'h00;
      for (int i = 0; i < 63; i++) s = s + mem[i];
      return CKS_EN && (s == mem[63]);
   endfunction

   task automatic load_expect(input int n);
      exp_q.delete();
      frames.delete();
      for (int i = 0; i < n; i++) exp_q.push_back({8'(i), mem[i]});
   endtask

   task automatic run_txn(input string name, input bit present, input int exp_bytes,
                          input bit exp_err, input bit exp_cks, output int cyc);
      int n0;
      load_expect(exp_bytes);
      n0 = valid_cnt;
      @(negedge clk);
      start = 1'b1;
      mod_def0 = ~present;
      @(negedge clk);
      start = 1'b0;
      check({name, "_busy_rise"}, busy, present);
      cyc = 1;
      while (!done && cyc < BUDGET) begin
         start = present && (cyc == 50);
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      check({name, "_done"}, done, 1);
      check({name, "_busy_fall"}, busy, 0);
      check({name, "_err"}, err, exp_err);
      check({name, "_cks_ok"}, cks_ok, exp_cks);
      check({name, "_nbytes"}, valid_cnt - n0, exp_bytes);
      check({name, "_queue_left"}, exp_q.size(), 0);
      $display("txn %s: cycles=%0d bytes=%0d err=%0d cks_ok=%0d", name, cyc, valid_cnt - n0, err, cks_ok);
   endtask

   int cyc, n0, s0;
   logic [7:0] sum;

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 8'(i + 3);
      repeat (3) @(negedge clk);
      check("rst_scl_oe", scl_oe, 0);
      check("rst_sda_oe", sda_oe, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_valid", valid, 0);
      res_n = 1'b1;
      repeat (5) @(negedge clk);

      // normal read with 0x03.. pattern
      s0 = stop_cnt;
      run_txn("normal", 1, NUM_BYTES, 0, cks_expected(), cyc);
      check("normal_nframes", frames.size(), 3);
      if (frames.size() == 3) begin
         check("frame_addr_w", frames[0], 8'hA0);
         check("frame_word", frames[1], 8'h00);
         check("frame_addr_r", frames[2], 8'hA1);
      end
      check("normal_stop", stop_cnt - s0, 1);

      // device NACKs the write address
      nack_a0 = 1'b1;
      s0 = stop_cnt;
      run_txn("nack", 1, 0, 1, 0, cyc);
      check("nack_stop", stop_cnt - s0, 1);
      check("nack_nframes", frames.size(), 1);
      nack_a0 = 1'b0;

      // module absent
      drove = 1'b0;
      run_txn("absent", 0, 0, 1, 0, cyc);
      check("absent_fast", cyc <= 3, 1);
      check("absent_no_drive", drove, 0);
      mod_def0 = 1'b0;
      repeat (3) @(negedge clk);

      // clock stretch on byte 5 with a correct checksum byte
      sum = 8'h00;
      for (int i = 0; i < 63; i++) sum = sum + mem[i];
      mem[63] = sum;
      stretch_byte = 5;
      stretched = 1'b0;
      hi_meas = 0;
      run_txn("stretch_cks", 1, NUM_BYTES, 0, CKS_EN, cyc);
      check("stretch_seen", stretched, 1);
      check("scl_high_after_stretch", hi_meas >= 2 * CLK_DIV, 1);
      stretch_byte = -1;

      // corrupted checksum byte
      mem[63] = sum + 8'd1;
      run_txn("cks_bad", 1, NUM_BYTES, 0, 0, cyc);

      // reset during byte 10, then a fresh read
      load_expect(NUM_BYTES);
      n0 = valid_cnt;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      cyc = 0;
      while ((valid_cnt - n0) < 10 && cyc < BUDGET) begin
         @(negedge clk);
         cyc++;
      end
      check("rst_mid_reached", valid_cnt - n0, 10);
      repeat (3) @(negedge clk);
      res_n = 1'b0;
      #1;
      check("rst_mid_scl_oe", scl_oe, 0);
      check("rst_mid_sda_oe", sda_oe, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_valid", valid, 0);
      check("rst_mid_data", data, 0);
      check("rst_mid_addr", addr, 0);
      exp_q.delete();
      repeat (3) @(negedge clk);
      res_n = 1'b1;
      repeat (5) @(negedge clk);
      run_txn("after_reset", 1, NUM_BYTES, 0, 0, cyc);

      // module pulled during byte 3
      load_expect(NUM_BYTES);
      n0 = valid_cnt;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      cyc = 0;
      while ((valid_cnt - n0) < 3 && cyc < BUDGET) begin
         @(negedge clk);
         cyc++;
      end
      mod_def0 = 1'b1;
      cyc = 0;
      while (!done && cyc < BUDGET) begin
         @(negedge clk);
         cyc++;
      end
      check("abort_done", done, 1);
      check("abort_err", err, 1);
      check("abort_partial", (valid_cnt - n0) < NUM_BYTES, 1);
      @(negedge clk);
      check("abort_scl_released", scl_oe, 0);
      check("abort_sda_released", sda_oe, 0);
      $display("txn abort: bytes=%0d err=%0d", valid_cnt - n0, err);
      exp_q.delete();
      mod_def0 = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sfp_id_reader.md
SFP_ID_READER -- requirements
Module: sfp_id_reader

Interface
REQ-001 Parameter CLK_DIV, default 100: system clocks per SCL quarter-bit (40 MHz / (4*100) = 100 kHz SCL).
REQ-002 Parameter NUM_BYTES, default 64: serial ID bytes read per transaction, legal 1..256.
REQ-003 Parameter DEV_ADDR, default 7'h50: 7-bit two-wire address of the SFP serial ID EEPROM.
REQ-004 i_clk  in  1  40 MHz system clock, single clock domain.
REQ-005 i_res_n  in  1  reset, asynchronous assert, active-low.
REQ-006 i_start  in  1  one-cycle request to begin a read transaction.
REQ-007 i_mod_def0  in  1  SFP MOD_DEF(0); low means module present.
REQ-008 i_scl / i_sda  in  1 each  sensed levels of MOD_DEF(1) / MOD_DEF(2).
REQ-009 o_scl_oe / o_sda_oe  out  1 each  1 drives the line low, 0 releases it; top-level tristate applies them.
REQ-010 o_busy  out  1  transaction in progress.
REQ-011 o_data / o_addr / o_valid  out  8/8/1  received byte, its EEPROM offset, one-cycle strobe.
REQ-012 o_done  out  1  one-cycle pulse at transaction end, success or abort.
REQ-013 o_err  out  1  last transaction aborted (NACK or module absent/removed); held until the next i_start.
REQ-014 o_cks_ok  out  1  CC_BASE checksum result, valid from o_done until the next i_start.

Function
REQ-015 Quarter tick from a counter 0..CLK_DIV-1; every bit spans 4 quarters: SCL low/low/high/high; SDA changes in Q0, sampled in Q2.
REQ-016 Clock stretching: while o_scl_oe=0 and i_scl samples low, the quarter counter holds.
REQ-017 States: IDLE, START, ADDR_W, WORD_ADDR, RSTART, ADDR_R, READ, MACK, STOP, DONE.
REQ-018 IDLE->START on i_start only when i_mod_def0=0; i_start with i_mod_def0=1 -> DONE with o_err=1 and no bus activity.
REQ-019 i_start while o_busy=1 is ignored.
REQ-020 Sequence: START, {DEV_ADDR,0}, ACK, 8'h00, ACK, repeated START, {DEV_ADDR,1}, ACK, NUM_BYTES data bytes, STOP.
REQ-021 Bytes are MSB first; the slave ACK bit is sampled in Q2 of the 9th bit; SDA=1 is a NACK.
REQ-022 Master ACKs (SDA low) every data byte except the last, which gets NACK (SDA released).
REQ-023 A NACK in ADDR_W, WORD_ADDR or ADDR_R goes to STOP, then DONE with o_err=1.
REQ-024 i_mod_def0 high at any cycle while busy: abort at the next bit boundary, go to STOP, then DONE with o_err=1.
REQ-025 o_valid pulses one cycle after the Q2 sample of data bit 0; o_addr counts 0..NUM_BYTES-1 and wraps 8'hFF->8'h00 only for NUM_BYTES=256.
REQ-026 START: SDA falls while SCL high. STOP: SDA rises while SCL high. Both lines are released in IDLE.
REQ-027 o_busy rises the cycle after an accepted i_start and falls in the same cycle as o_done.

Reset
REQ-028 When i_res_n=0, all state returns to IDLE immediately and every output is 0 (lines released); a reset mid-transaction drives no STOP.

Configuration
REQ-029 SFP_ID_CHECKSUM_EN defined: accumulate bytes at offsets 0..62 mod 256 and compare with offset 63; o_cks_ok=1 at o_done when equal, no error and NUM_BYTES>=64.
REQ-030 SFP_ID_CHECKSUM_EN undefined: no accumulator is built and o_cks_ok is tied to 0.

Verification
REQ-031 EEPROM model at 0x50 holding offsets 0..63 = 0x03,0x04,...; i_start -> 64 o_valid strobes with matching data, o_addr 0..63, o_done, o_err=0, bus frames 0xA0/0x00/0xA1.
REQ-032 Model NACKs 0xA0 -> STOP seen, o_done with o_err=1, zero o_valid strobes.
REQ-033 i_mod_def0=1 at i_start -> o_done within 3 cycles, o_err=1, SCL/SDA never driven.
REQ-034 Model stretches SCL low for 500 cycles on byte 5 -> data still correct; the SCL-high period after release is >=2*CLK_DIV cycles.
REQ-035 i_res_n pulsed low during byte 10 -> outputs 0 and both lines released the same cycle; a new i_start completes a normal read.
REQ-036 With SFP_ID_CHECKSUM_EN, byte 63 = correct sum -> o_cks_ok=1; byte 63 corrupted by +1 -> o_cks_ok=0.
